// File: rtl/tdm_frame_deser.sv
// Receive end of the serial mic-sum link: deserialises lr_clk-framed words into a
// small FIFO behind a valid/ready stream, flagging short frames and dropped words.
module tdm_frame_deser #(
  parameter int N_CH       = 4,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lr_clk,
  input  logic                sd_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SAMPLE_W-1:0] m_data,
  output logic [CH_W-1:0]     m_ch,
  output logic                m_first,
  output logic                overflow,
  output logic                frame_err
);

  localparam int BIT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = CH_W + 1 + SAMPLE_W;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic                lr_q, lr_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic                push_q, push_d;
  logic [ENT_W-1:0]    push_word_q, push_word_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                frame_err_q, frame_err_d;

  logic lr_edge, word_done, last_ch;
  logic fifo_full, fifo_pop, fifo_wr;

  assign lr_edge   = lr_clk & ~lr_q;
  assign word_done = (bit_cnt_q == BIT_W'(SAMPLE_W - 1));
  assign last_ch   = (ch_cnt_q == CH_W'(N_CH - 1));

  always_comb begin
    state_d     = state_q;
    lr_d        = lr_clk;
    bit_cnt_d   = bit_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE, HOLD: begin
        if (lr_edge) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
        end
      end
      SHIFT: begin
        // An edge on the frame's final bit is a clean frame boundary, anything earlier is short.
        if (lr_edge && !(word_done && last_ch)) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          ch_cnt_d    = '0;
          shreg_d     = '0;
        end else begin
          shreg_d = {shreg_q[SAMPLE_W-2:0], sd_in};
          if (word_done) begin
            push_d      = 1'b1;
            push_word_d = {ch_cnt_q, (ch_cnt_q == '0), shreg_d};
            bit_cnt_d   = '0;
            if (last_ch) begin
              ch_cnt_d = '0;
              state_d  = lr_edge ? SHIFT : HOLD;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign fifo_full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign fifo_pop  = m_valid && m_ready;
  assign fifo_wr   = push_q && (!fifo_full || fifo_pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_q && fifo_full && !fifo_pop);
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = push_word_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_wr, fifo_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lr_q        <= 1'b1;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_q        <= lr_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_valid                   = (count_q != '0);
  assign {m_ch, m_first, m_data}   = mem_q[rd_ptr_q];
  assign overflow                  = overflow_q;
  assign frame_err                 = frame_err_q;

endmodule

// File: tb/tb_tdm_frame_deser.sv
// Bench for tdm_frame_deser: a precomputed per-cycle stimulus stream, a frame-level
// word schedule derived from edge spacing, and a queue model of the output FIFO.
module tb_tdm_frame_deser;
  localparam int N_CH       = 4;
  localparam int SAMPLE_W   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAXC       = 2500;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                lr_clk = 1'b0;
  logic                sd_in = 1'b0;
  logic                m_ready = 1'b0;
  logic                m_valid, m_first, overflow, frame_err;
  logic [SAMPLE_W-1:0] m_data;
  logic [1:0]          m_ch;

  tdm_frame_deser #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .lr_clk(lr_clk), .sd_in(sd_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
    .m_first(m_first), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  bit lr_a [MAXC];
  bit sd_a [MAXC];
  bit rst_a [MAXC];
  bit rdy_a [MAXC];
  bit err_at [MAXC];
  int push_at [MAXC];
  int edges[$];
  int q[$];
  int pos, ncyc, cyc, beat_cnt;
  int pass_cnt, fail_cnt, total_cnt;
  bit m_ovf, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // A frame: lr_clk rises at pos, 32 data bits MSB first follow, next edge at pos+len.
  task automatic frame(input logic [31:0] data, input int len);
    for (int k = 0; k < len / 2; k++) lr_a[pos + k] = 1'b1;
    for (int k = 0; k < 32; k++) sd_a[pos + 1 + k] = data[31 - k];
    pos += len;
  endtask

  task automatic set_rdy(input int from, input int to, input bit val);
    for (int i = from; i < to; i++) rdy_a[i] = val;
  endtask

  // Words of a frame survive if their last bit precedes the next edge (or the frame is
  // full length) and no reset hits before the word reaches the FIFO.
  task automatic build_schedule();
    int e, n, r, t, ent;
    bit prev, full;
    logic [7:0] w;
    for (int c = 0; c < ncyc; c++) begin
      prev = (c == 0) ? 1'b1 : (rst_a[c-1] ? 1'b1 : lr_a[c-1]);
      if (!rst_a[c] && lr_a[c] && !prev) edges.push_back(c);
    end
    for (int i = 0; i < edges.size(); i++) begin
      e = edges[i];
      n = (i + 1 < edges.size()) ? edges[i+1] : 4 * MAXC;
      r = 4 * MAXC;
      for (int c = ncyc - 1; c > e; c--) if (rst_a[c]) r = c;
      full = (n - e >= 32);
      for (int ch = 0; ch < N_CH; ch++) begin
        t = e + 8 * (ch + 1);
        if ((full || t < n) && t + 1 < r && t + 1 < ncyc) begin
          w = '0;
          for (int j = 0; j < 8; j++) w = {w[6:0], sd_a[t - 7 + j]};
          ent = (ch << 9) | ((ch == 0 ? 1 : 0) << 8) | int'(w);
          push_at[t + 1] = ent;
        end
      end
      if (!full && n < r && n < ncyc) err_at[n] = 1'b1;
    end
  endtask

  initial begin
    int t1, t2, t6, sz;
    bit pop;
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0; beat_cnt = 0;
    m_ovf = 0; m_err = 0;
    for (int i = 0; i < MAXC; i++) begin
      lr_a[i] = 0; sd_a[i] = 1'($urandom_range(0, 1)); rst_a[i] = 0;
      rdy_a[i] = ($urandom_range(0, 3) != 0); push_at[i] = -1; err_at[i] = 0;
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1;
    pos = 6;
    // Known frame with a ready consumer.
    t1 = pos; frame(32'hA53CFF01, 40); pos += 10; set_rdy(t1, pos, 1);
    // Stalled consumer: second frame overflows a FIFO holding A5..01.
    t2 = pos; frame(32'hA53CFF01, 40); frame($urandom(), 40); pos += 20; set_rdy(t2, pos, 0);
    set_rdy(pos, pos + 20, 1); pos += 20;
    // Short frame after 12 bits, then a normal one.
    frame($urandom(), 13); frame($urandom(), 40);
    // Back-to-back frames with the edge on bit 31, then a long frame.
    frame($urandom(), 32); frame($urandom(), 32); frame($urandom(), 40); pos += 5;
    // Reset at bit 5 of word 2, then a clean frame.
    t6 = pos; frame($urandom(), 40);
    for (int i = 22; i < 25; i++) rst_a[t6 + i] = 1;
    set_rdy(t6, t6 + 25, 0);
    frame($urandom(), 40); pos += 10;
    // Random frame lengths and gaps.
    for (int i = 0; i < 14; i++) begin
      frame($urandom(), $urandom_range(4, 45));
      if ($urandom_range(0, 2) == 0) pos += $urandom_range(1, 6);
    end
    frame($urandom(), 40);
    set_rdy(pos, pos + 40, 1); pos += 40;
    ncyc = pos;
    build_schedule();

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rst = rst_a[c]; lr_clk = lr_a[c]; sd_in = sd_a[c]; m_ready = rdy_a[c];
      @(posedge clk);
      #1;
      cyc = c;
      if (rst_a[c]) begin
        q.delete(); m_ovf = 0; m_err = 0;
      end else begin
        sz  = q.size();
        pop = (sz > 0) && rdy_a[c];
        if (pop) begin
          $display("beat %0d cycle %0d ch=%0d first=%0d data=%02h", beat_cnt, c,
                   (q[0] >> 9) & 3, (q[0] >> 8) & 1, q[0] & 8'hff);
          beat_cnt++;
          void'(q.pop_front());
        end
        if (push_at[c] >= 0) begin
          if (sz == FIFO_DEPTH && !pop) m_ovf = 1;
          else q.push_back(push_at[c]);
        end
        if (err_at[c]) m_err = 1;
      end
      check("m_valid", 32'(m_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("head", 32'({m_ch, m_first, m_data}), 32'(q[0]));
      if (rst_a[c]) check("reset_head", 32'({m_ch, m_first, m_data}), 32'd0);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("frame_err", 32'(frame_err), 32'(m_err));
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
